ctrl_unit_mc: RTL and testbench

Parametrised multi-cycle CPU control unit that sequences fetch, decode, register read, execute, memory and register write for one instruction at a time. It drives a one-hot state vector that gates the datapath, and issues single-cycle memory requests over a ready/data-ready handshake. Beyond the basic sequencer, it adds:
- configurable instruction and opcode widths and opcode codes
- a distinct memory-request phase and a write-type qualifier
- a pipeline stall input
- a memory timeout with a sticky fault
- a HALT opcode with resume
- a retired-instruction counter

---
 rtl/ctrl_unit_mc.sv | 120 ++++++++++++
 tb/tb_ctrl_unit_mc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multi-cycle CPU control sequencer with a memory request/wait
// sub-machine, stall, timeout fault, halt/resume and a retired-instruction counter.
module ctrl_unit_mc #(
    parameter int                INSTR_W  = 16,
    parameter int                OP_W     = 4,
    parameter logic [OP_W-1:0]   OP_READ  = 4'hA,
    parameter logic [OP_W-1:0]   OP_WRITE = 4'hB,
    parameter logic [OP_W-1:0]   OP_HALT  = 4'hF,
    parameter int                TIMEOUT  = 200,
    parameter int                TMO_W    = 8,
    parameter int                CNT_W    = 16
) (
    input  logic               I_clk,
    input  logic               I_reset,
    input  logic [INSTR_W-1:0] I_instruction,
    input  logic               I_mem_ready,
    input  logic               I_data_ready,
    input  logic               I_stall,
    input  logic               I_resume,
    output logic [6:0]         O_state,
    output logic               O_execute,
    output logic               O_mem_write,
    output logic               O_fault,
    output logic               O_halted,
    output logic [CNT_W-1:0]   O_retired
);
    typedef enum logic [6:0] {
        S_FETCH     = 7'b0000001,
        S_DECODE    = 7'b0000010,
        S_REGREAD   = 7'b0000100,
        S_EXECUTE   = 7'b0001000,
        S_MEM       = 7'b0010000,
        S_WRITEBACK = 7'b0100000,
        S_HALT      = 7'b1000000
    } state_t;
    typedef enum logic {P_REQ, P_WAIT} phase_t;

    state_t           state, state_nx;
    phase_t           phase, phase_nx;
    logic [TMO_W-1:0] cnt, cnt_nx;
    logic [OP_W-1:0]  op, op_nx;
    logic [OP_W-1:0]  opcode;
    logic             fault_nx, retire, mem_state, is_store, waiting, req, done, tmo;
    logic             unused_instr;

    assign opcode       = I_instruction[INSTR_W-1 -: OP_W];
    assign unused_instr = ^I_instruction;
    assign mem_state    = (state == S_FETCH) || (state == S_MEM);
    assign is_store     = (state == S_MEM) && (op == OP_WRITE);
    assign waiting      = mem_state && (phase == P_WAIT);
    assign req          = mem_state && (phase == P_REQ) && I_mem_ready;
    assign done         = waiting && (is_store || I_data_ready);
    // data_ready on the final wait cycle wins over the timeout
    assign tmo          = waiting && !is_store && !I_data_ready && (cnt == TMO_W'(TIMEOUT - 1));
    assign O_state      = state;
    assign O_halted     = (state == S_HALT);

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        op_nx    = op;
        fault_nx = O_fault;
        retire   = 1'b0;
        if (req) begin
            phase_nx = P_WAIT;
            cnt_nx   = '0;
        end else if (done) begin
            phase_nx = P_REQ;
        end else if (tmo) begin
            phase_nx = P_REQ;
            cnt_nx   = '0;
            fault_nx = 1'b1;
            state_nx = S_HALT;
        end else if (waiting) begin
            cnt_nx = cnt + 1'b1;
        end
        case (state)
            S_FETCH:     if (done) state_nx = S_DECODE;
            S_DECODE: begin
                op_nx    = opcode;
                state_nx = (opcode == OP_HALT) ? S_HALT : S_REGREAD;
            end
            S_REGREAD:   if (!I_stall) state_nx = S_EXECUTE;
            S_EXECUTE:   if (!I_stall) state_nx = (op == OP_READ || op == OP_WRITE) ? S_MEM : S_WRITEBACK;
            S_MEM: if (done) begin
                state_nx = is_store ? S_FETCH : S_WRITEBACK;
                retire   = is_store;
            end
            S_WRITEBACK: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            S_HALT:      if (I_resume && !O_fault) state_nx = S_FETCH;
            default:     state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            state       <= S_FETCH;
            phase       <= P_REQ;
            cnt         <= '0;
            op          <= '0;
            O_fault     <= 1'b0;
            O_execute   <= 1'b0;
            O_mem_write <= 1'b0;
            O_retired   <= '0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            cnt         <= cnt_nx;
            op          <= op_nx;
            O_fault     <= fault_nx;
            O_execute   <= req;
            O_mem_write <= req && is_store;
            O_retired   <= O_retired + CNT_W'(retire);
        end
    end
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb_ctrl_unit_mc: vector-table and hand-sequence checks of ctrl_unit_mc
// (TIMEOUT = 4, CNT_W = 2) with an expected-result queue.
module tb_ctrl_unit_mc;
    localparam logic [6:0] F = 7'h01, D = 7'h02, R = 7'h04, E = 7'h08,
                           M = 7'h10, W = 7'h20, H = 7'h40;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        rdy = 1'b0, dr = 1'b0, stl = 1'b0, res = 1'b0;
    logic [6:0]  st;
    logic        ex, wr, flt, hlt;
    logic [1:0]  ret;

    typedef struct {
        logic [15:0] instr;
        logic        rdy, dr, stl, res;
        logic [12:0] expv;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] sb[$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    ctrl_unit_mc #(.TIMEOUT(4), .CNT_W(2)) dut (
        .I_clk(clk), .I_reset(rst_n), .I_instruction(instr),
        .I_mem_ready(rdy), .I_data_ready(dr), .I_stall(stl), .I_resume(res),
        .O_state(st), .O_execute(ex), .O_mem_write(wr), .O_fault(flt),
        .O_halted(hlt), .O_retired(ret)
    );

    function automatic logic [12:0] pk(logic [6:0] s, logic e, logic w, logic f, logic [1:0] r);
        return {s, e, w, f, (s == H), r};
    endfunction

    function automatic void add(logic [15:0] i, logic a, logic b, logic c, logic d,
                                logic [6:0] s, logic e, logic w, logic f, logic [1:0] r);
        vec_t v;
        v.instr = i; v.rdy = a; v.dr = b; v.stl = c; v.res = d;
        v.expv  = pk(s, e, w, f, r);
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [12:0] e);
        logic [12:0] g;
        g = {st, ex, wr, flt, hlt, ret};
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%b ex=%b wr=%b flt=%b hlt=%b ret=%0d, expected st=%b ex=%b wr=%b flt=%b hlt=%b ret=%0d",
                     name, g[12:6], g[5], g[4], g[3], g[2], g[1:0],
                     e[12:6], e[5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    task automatic run_table(string tag);
        foreach (vecs[i]) begin
            instr = vecs[i].instr; rdy = vecs[i].rdy; dr = vecs[i].dr;
            stl = vecs[i].stl; res = vecs[i].res;
            sb.push_back(vecs[i].expv);
            @(posedge clk); #1;
            check($sformatf("%s_row%0d", tag, i), sb.pop_front());
        end
    endtask

    initial begin
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset", pk(F, 0, 0, 0, 0));
        rdy = 1'b0;
        rst_n = 1'b1;

        // ALU op
        add(16'h1000,1,0,0,0, F,1,0,0,0);
        add(16'h1000,1,0,0,0, F,0,0,0,0);
        add(16'h1000,1,1,0,0, D,0,0,0,0);
        add(16'h1000,1,0,0,0, R,0,0,0,0);
        add(16'h1000,1,0,0,0, E,0,0,0,0);
        add(16'h1000,1,0,0,0, W,0,0,0,0);
        add(16'h1000,1,0,0,0, F,0,0,0,1);
        // store: second pulse with mem_write, MEM two cycles, no WRITEBACK
        add(16'hB000,1,0,0,0, F,1,0,0,1);
        add(16'hB000,1,1,0,0, D,0,0,0,1);
        add(16'hB000,1,0,0,0, R,0,0,0,1);
        add(16'hB000,1,0,0,0, E,0,0,0,1);
        add(16'hB000,1,0,0,0, M,0,0,0,1);
        add(16'hB000,1,0,0,0, M,1,1,0,1);
        add(16'hB000,1,0,0,0, F,0,0,0,2);
        // load: stall ignored in DECODE, opcode latched, 3-cycle EXECUTE stall, ready low 5 cycles
        add(16'hA123,1,0,0,0, F,1,0,0,2);
        add(16'hA123,1,1,0,0, D,0,0,0,2);
        add(16'hA123,0,0,1,0, R,0,0,0,2);
        add(16'h1000,0,0,0,0, E,0,0,0,2);
        for (int k = 0; k < 3; k++) add(16'h1000,0,0,1,0, E,0,0,0,2);
        add(16'h1000,0,0,0,0, M,0,0,0,2);
        for (int k = 0; k < 5; k++) add(16'h1000,0,1,0,0, M,0,0,0,2);
        add(16'h1000,1,0,0,0, M,1,0,0,2);
        add(16'h1000,0,0,0,0, M,0,0,0,2);
        add(16'h1000,0,1,0,0, W,0,0,0,2);
        add(16'h1000,0,0,0,0, F,0,0,0,3);
        // ALU op with REGREAD stall; retired wraps 3 -> 0
        add(16'h2000,1,0,0,0, F,1,0,0,3);
        add(16'h2000,1,1,0,0, D,0,0,0,3);
        add(16'h2000,1,0,0,0, R,0,0,0,3);
        add(16'h2000,1,0,1,0, R,0,0,0,3);
        add(16'h2000,1,0,0,0, E,0,0,0,3);
        add(16'h2000,1,0,0,0, W,0,0,0,3);
        add(16'h2000,1,0,0,0, F,0,0,0,0);
        // halt and resume
        add(16'hF000,1,0,0,0, F,1,0,0,0);
        add(16'hF000,1,1,0,0, D,0,0,0,0);
        add(16'hF000,1,0,0,0, H,0,0,0,0);
        add(16'hF000,1,0,0,0, H,0,0,0,0);
        add(16'hF000,1,0,0,1, F,0,0,0,0);
        // fetch timeout: fault four cycles after the pulse, resume ignored
        add(16'h1000,1,0,0,1, F,1,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,0,0,0, H,0,0,1,0);
        add(16'h1000,0,0,0,1, H,0,0,1,0);
        add(16'h1000,1,0,0,0, H,0,0,1,0);
        run_table("a");

        #2 rst_n = 1'b0;
        #1 check("async_rst_fault", pk(F, 0, 0, 0, 0));
        rdy = 1'b1;
        @(posedge clk); #1 check("rst_held", pk(F, 0, 0, 0, 0));
        rdy = 1'b0;
        rst_n = 1'b1;

        // data_ready on the last wait cycle beats the timeout
        vecs.delete();
        add(16'h1000,1,0,0,0, F,1,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,0);
        add(16'h1000,0,1,0,0, D,0,0,0,0);
        add(16'h1000,0,0,0,0, R,0,0,0,0);
        add(16'h1000,0,0,0,0, E,0,0,0,0);
        add(16'h1000,0,0,0,0, W,0,0,0,0);
        add(16'h1000,0,0,0,0, F,0,0,0,1);
        add(16'h1000,1,0,0,0, F,1,0,0,1);
        run_table("b");

        // reset during WAIT, with the request pulse currently high
        #2 rst_n = 1'b0;
        #1 check("async_rst_wait", pk(F, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("idle_after_rst", pk(F, 0, 0, 0, 0));
        rdy = 1'b1;
        @(posedge clk); #1 check("req_after_rst", pk(F, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
